traffic_cmd_rx: RTL and testbench
=================================

TRAFFIC_CMD_RX -- requirements
Module: traffic_cmd_rx

Interface
REQ-001 Parameter UARTWidth, default 8: byte width on both UART-side ports.
REQ-002 Parameter THPWidth, default 104: command word width ({Cmd[7:0], Field0[31:0], Field1[31:0], Field2[31:0]}); SHALL be a multiple of UARTWidth.
REQ-003 Parameter DBaseWidth, default 32: response word width; SHALL be a multiple of UARTWidth.
REQ-004 Parameter TimeoutCycles, default 100000: inter-byte idle limit in Clock cycles.
REQ-005 Clock  in  1  sole clock; all logic on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 UARTIn  in  UARTWidth  received byte.
REQ-008 UARTInValid  in  1  UARTIn is valid.
REQ-009 UARTInReady  out  1  block accepts UARTIn.
REQ-010 CmdOut  out  THPWidth  assembled command word.
REQ-011 CmdOutValid  out  1  CmdOut is valid.
REQ-012 CmdOutReady  in  1  consumer accepts CmdOut.
REQ-013 RespIn  in  DBaseWidth  response word to serialize.
REQ-014 RespInValid  in  1  RespIn is valid.
REQ-015 RespInReady  out  1  block accepts RespIn.
REQ-016 UARTOut  out  UARTWidth  transmit byte.
REQ-017 UARTOutValid  out  1  UARTOut is valid.
REQ-018 UARTOutReady  in  1  UART accepts UARTOut.
REQ-019 FrameDrop  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-020 Every handshake SHALL complete on a cycle where Valid and Ready are both high; Ready SHALL NOT depend combinationally on the same port's Valid.
REQ-021 The RX FSM SHALL have states RX_COLLECT and RX_HOLD; UARTInReady = (state == RX_COLLECT).
REQ-022 In RX_COLLECT, each accepted byte SHALL shift into the command register from the LSB side, so the first byte of a frame lands in CmdOut[THPWidth-1 -: UARTWidth] (MSB-first).
REQ-023 A byte counter (0 to THPWidth/UARTWidth-1) SHALL increment per accepted byte; acceptance of the last byte SHALL move to RX_HOLD and clear the counter.
REQ-024 CmdOutValid = (state == RX_HOLD); it SHALL assert the cycle after the last-byte handshake.
REQ-025 CmdOut SHALL remain stable throughout RX_HOLD.
REQ-026 In RX_HOLD, CmdOutReady high SHALL return the FSM to RX_COLLECT on the next cycle; no byte SHALL be accepted during RX_HOLD.
REQ-027 The TX FSM SHALL have states TX_IDLE and TX_SEND; RespInReady = (state == TX_IDLE).
REQ-028 A RespIn handshake SHALL capture RespIn and enter TX_SEND the next cycle.
REQ-029 In TX_SEND, UARTOutValid = 1 and UARTOut = the top UARTWidth bits of the shift register; each UARTOut handshake SHALL shift the register left by UARTWidth.
REQ-030 After the (DBaseWidth/UARTWidth)-th byte handshake, the TX FSM SHALL return to TX_IDLE; UARTOut SHALL be stable while UARTOutReady is low.
REQ-031 The RX and TX paths SHALL be fully independent; simultaneous activity on both SHALL NOT stall either path.

Reset
REQ-032 While Reset is low: RX_COLLECT, TX_IDLE, counters = 0, CmdOut = 0, UARTOut = 0, CmdOutValid = 0, UARTOutValid = 0, FrameDrop = 0.
REQ-033 A reset mid-frame or mid-response SHALL discard all partial state; the next frame SHALL decode from byte 0.

Configuration
REQ-034 With TRAFFIC_CMD_TIMEOUT_EN defined: in RX_COLLECT with a nonzero byte counter, an idle counter SHALL count cycles without a byte handshake and SHALL clear on every handshake; reaching TimeoutCycles SHALL zero the byte counter and command register and pulse FrameDrop for one cycle.
REQ-035 Without TRAFFIC_CMD_TIMEOUT_EN: no idle counter SHALL be present; FrameDrop SHALL be tied to 0; partial frames SHALL be retained indefinitely.

Verification
REQ-036 Bytes 03 00 00 00 01 00 00 00 64 00 00 00 00 with CmdOutReady=1 -> CmdOutValid high exactly one cycle after byte 13; CmdOut=0x03_00000001_00000064_00000000.
REQ-037 CmdOutReady held 0 for 20 cycles after a frame -> UARTInReady 0 and CmdOut unchanged throughout; the next byte is accepted no earlier than one cycle after CmdOutReady rises.
REQ-038 RespIn=0xDEADBEEF with UARTOutReady toggling every cycle -> UARTOut sequence DE, AD, BE, EF; RespInReady 0 until the cycle after EF is accepted.
REQ-039 Macro on, TimeoutCycles=100: 5 bytes, then a 100-cycle gap -> one FrameDrop pulse; a following 13-byte frame decodes correctly. Macro off, same stimulus -> no pulse; the frame completes on the 8th following byte.
REQ-040 Reset asserted after RX byte 7 and TX byte 2 -> all outputs reach REQ-032 values; no residual bytes appear on UARTOut; the next frame decodes correctly.
REQ-041 Frame reception concurrent with a 0x12345678 response -> both complete with the same timing as in isolation.

Source files
------------

// File: rtl/traffic_cmd_rx_if.sv
// Handshake bundle for traffic_cmd_rx: UART byte streams, command word out and response word in.
interface traffic_cmd_rx_if #(
  parameter int unsigned UARTWidth  = 8,
  parameter int unsigned THPWidth   = 104,
  parameter int unsigned DBaseWidth = 32
);
  logic [UARTWidth-1:0]  UARTIn;
  logic                  UARTInValid;
  logic                  UARTInReady;
  logic [THPWidth-1:0]   CmdOut;
  logic                  CmdOutValid;
  logic                  CmdOutReady;
  logic [DBaseWidth-1:0] RespIn;
  logic                  RespInValid;
  logic                  RespInReady;
  logic [UARTWidth-1:0]  UARTOut;
  logic                  UARTOutValid;
  logic                  UARTOutReady;
  logic                  FrameDrop;

  modport slave (
    input  UARTIn, UARTInValid, CmdOutReady, RespIn, RespInValid, UARTOutReady,
    output UARTInReady, CmdOut, CmdOutValid, RespInReady, UARTOut, UARTOutValid, FrameDrop
  );

  modport master (
    output UARTIn, UARTInValid, CmdOutReady, RespIn, RespInValid, UARTOutReady,
    input  UARTInReady, CmdOut, CmdOutValid, RespInReady, UARTOut, UARTOutValid, FrameDrop
  );
endinterface

// File: rtl/traffic_cmd_rx.sv
// UART byte stream <-> command/response word bridge with independent RX and TX FSMs.
// Define TRAFFIC_CMD_TIMEOUT_EN to discard partial frames after TimeoutCycles idle cycles.
module traffic_cmd_rx #(
  parameter int unsigned UARTWidth     = 8,
  parameter int unsigned THPWidth      = 104,
  parameter int unsigned DBaseWidth    = 32,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic              Clock,
  input  logic              Reset,
  traffic_cmd_rx_if.slave   bus
);

  localparam int unsigned RxBytes = THPWidth / UARTWidth;
  localparam int unsigned TxBytes = DBaseWidth / UARTWidth;
  localparam int unsigned RxCntW  = (RxBytes > 1) ? $clog2(RxBytes) : 1;
  localparam int unsigned TxCntW  = (TxBytes > 1) ? $clog2(TxBytes) : 1;

  if ((THPWidth % UARTWidth) != 0 || (DBaseWidth % UARTWidth) != 0 || TimeoutCycles == 0)
  begin : g_bad_cfg
    $error("traffic_cmd_rx: word widths must be multiples of UARTWidth, TimeoutCycles nonzero");
  end

  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  rx_state_e             rx_state_q;
  logic [RxCntW-1:0]     rx_cnt_q;
  logic [THPWidth-1:0]   cmd_q;
  tx_state_e             tx_state_q;
  logic [TxCntW-1:0]     tx_cnt_q;
  logic [DBaseWidth-1:0] tx_sh_q;

  logic rx_hs;
  logic tx_hs;
  logic rx_timeout;

  assign rx_hs = (rx_state_q == RX_COLLECT) && bus.UARTInValid;
  assign tx_hs = (tx_state_q == TX_SEND) && bus.UARTOutReady;

`ifdef TRAFFIC_CMD_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TimeoutCycles + 1);

  logic [IdleW-1:0] idle_q;
  logic             drop_q;

  // Idle time only matters once a frame has started.
  assign rx_timeout = (rx_state_q == RX_COLLECT) && (rx_cnt_q != '0) && !rx_hs &&
                      (idle_q == IdleW'(TimeoutCycles - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idle_q <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= rx_timeout;
      if ((rx_state_q != RX_COLLECT) || (rx_cnt_q == '0) || rx_hs || rx_timeout) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IdleW'(1);
      end
    end
  end

  assign bus.FrameDrop = drop_q;
`else
  assign rx_timeout    = 1'b0;
  assign bus.FrameDrop = 1'b0;
`endif

  // RX: shift bytes in MSB-first, hold the word until the consumer takes it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_state_q <= RX_COLLECT;
      rx_cnt_q   <= '0;
      cmd_q      <= '0;
    end else begin
      case (rx_state_q)
        RX_COLLECT: begin
          if (rx_hs) begin
            cmd_q <= THPWidth'({cmd_q, bus.UARTIn});
            if (rx_cnt_q == RxCntW'(RxBytes - 1)) begin
              rx_cnt_q   <= '0;
              rx_state_q <= RX_HOLD;
            end else begin
              rx_cnt_q <= rx_cnt_q + RxCntW'(1);
            end
          end else if (rx_timeout) begin
            rx_cnt_q <= '0;
            cmd_q    <= '0;
          end
        end
        RX_HOLD: begin
          if (bus.CmdOutReady) begin
            rx_state_q <= RX_COLLECT;
          end
        end
      endcase
    end
  end

  // TX: capture a response word and emit it top byte first; zeros shift in behind it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.RespInValid) begin
            tx_sh_q    <= bus.RespIn;
            tx_state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_hs) begin
            tx_sh_q <= tx_sh_q << UARTWidth;
            if (tx_cnt_q == TxCntW'(TxBytes - 1)) begin
              tx_cnt_q   <= '0;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_cnt_q <= tx_cnt_q + TxCntW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.UARTInReady  = (rx_state_q == RX_COLLECT);
  assign bus.CmdOutValid  = (rx_state_q == RX_HOLD);
  assign bus.CmdOut       = cmd_q;
  assign bus.RespInReady  = (tx_state_q == TX_IDLE);
  assign bus.UARTOutValid = (tx_state_q == TX_SEND);
  assign bus.UARTOut      = tx_sh_q[DBaseWidth-1 -: UARTWidth];

endmodule

// File: tb/tb_traffic_cmd_rx.sv
// Directed bench for traffic_cmd_rx: vector table of frames/responses plus hold, timeout,
// reset and concurrency sequences. Honours TRAFFIC_CMD_TIMEOUT_EN like the design.
module tb_traffic_cmd_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  traffic_cmd_rx_if #(.UARTWidth(8), .THPWidth(104), .DBaseWidth(32)) u_if ();

  traffic_cmd_rx #(
    .UARTWidth(8), .THPWidth(104), .DBaseWidth(32), .TimeoutCycles(100)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (u_if)
  );

  typedef struct {
    logic [103:0] frame;
    logic [103:0] exp_cmd;
    logic [31:0]  resp;
    bit           toggle;
    logic [31:0]  exp_tx;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Present one byte from a negedge and return on the negedge after its handshake.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    u_if.UARTIn      = b;
    u_if.UARTInValid = 1'b1;
    while (!u_if.UARTInReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_accept_timeout", 1, 0);
    @(negedge clk);
    u_if.UARTInValid = 1'b0;
  endtask

  task automatic send_frame(input logic [103:0] f);
    for (int i = 0; i < 13; i++) send_byte(f[103-8*i -: 8]);
  endtask

  task automatic run_tx(input logic [31:0] r, input bit tog, output logic [31:0] got,
                        output bit rdy_lo_ok, output bit stable_ok, output int ncyc);
    int n;
    int k;
    bit prev_stall;
    logic [7:0] last;
    got = '0; rdy_lo_ok = 1'b1; stable_ok = 1'b1; ncyc = 0;
    n = 0; k = 0; prev_stall = 1'b0; last = '0;
    u_if.RespIn      = r;
    u_if.RespInValid = 1'b1;
    while (!u_if.RespInReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    u_if.RespInValid = 1'b0;
    u_if.RespIn      = '0;
    n = 0;
    while (k < 4 && n < 200) begin
      u_if.UARTOutReady = tog ? 1'(n % 2) : 1'b1;
      if (u_if.RespInReady) rdy_lo_ok = 1'b0;
      if (prev_stall && u_if.UARTOut !== last) stable_ok = 1'b0;
      if (u_if.UARTOutValid && u_if.UARTOutReady) begin
        got = {got[23:0], u_if.UARTOut};
        k++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        last = u_if.UARTOut;
      end
      @(negedge clk);
      n++;
      ncyc++;
    end
    u_if.UARTOutReady = 1'b0;
    if (k < 4) chk("tx_bytes_timeout", 1, 0);
  endtask

  logic [31:0]  got;
  bit           rdy_ok, stab_ok, flag;
  int           txc, rx_cyc, t0, pulses;
  logic         rx_valid;
  logic [103:0] rx_cmd, f;

  initial begin
    vec[0] = '{104'h03_00000001_00000064_00000000, 104'h03_00000001_00000064_00000000,
               32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vec[1] = '{104'hFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 104'hFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
               32'h00000000, 1'b0, 32'h00000000};
    vec[2] = '{104'hA5_01234567_89ABCDEF_5A5AA5A5, 104'hA5_01234567_89ABCDEF_5A5AA5A5,
               32'h12345678, 1'b1, 32'h12345678};
    vec[3] = '{104'h01_80000000_00000000_00000001, 104'h01_80000000_00000000_00000001,
               32'h80000001, 1'b0, 32'h80000001};

    u_if.UARTIn = '0; u_if.UARTInValid = 1'b0; u_if.CmdOutReady = 1'b0;
    u_if.RespIn = '0; u_if.RespInValid = 1'b0; u_if.UARTOutReady = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {u_if.UARTInReady, u_if.CmdOutValid, u_if.RespInReady, u_if.UARTOutValid,
         u_if.FrameDrop, u_if.UARTOut}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    chk("reset_cmdout", u_if.CmdOut, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: frame decode then response serialisation
    u_if.CmdOutReady = 1'b1;
    for (int v = 0; v < 4; v++) begin
      f = vec[v].frame;
      for (int i = 0; i < 12; i++) send_byte(f[103-8*i -: 8]);
      chk("vec_valid_before_last", u_if.CmdOutValid, 0);
      send_byte(f[7:0]);
      chk("vec_valid_after_last", u_if.CmdOutValid, 1);
      chk("vec_cmd", u_if.CmdOut, vec[v].exp_cmd);
      @(negedge clk);
      chk("vec_valid_one_cycle", u_if.CmdOutValid, 0);
      run_tx(vec[v].resp, vec[v].toggle, got, rdy_ok, stab_ok, txc);
      chk("vec_tx_bytes", got, vec[v].exp_tx);
      chk("vec_respready_low_during_send", rdy_ok, 1);
      chk("vec_uartout_stable_on_stall", stab_ok, 1);
      chk("vec_respready_after_last", u_if.RespInReady, 1);
    end

    // Consumer stalls for 20 cycles with a byte waiting
    u_if.CmdOutReady = 1'b0;
    send_frame(vec[2].frame);
    chk("hold_valid", u_if.CmdOutValid, 1);
    u_if.UARTIn = 8'hAA;
    u_if.UARTInValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_ready_cmd", {u_if.UARTInReady, u_if.CmdOut}, {1'b0, vec[2].frame});
    end
    u_if.CmdOutReady = 1'b1;
    chk("hold_ready_at_release", u_if.UARTInReady, 0);
    @(negedge clk);
    chk("ready_after_release", u_if.UARTInReady, 1);
    @(negedge clk);
    u_if.UARTInValid = 1'b0;
    f = 104'hAA_11111111_22222222_33333333;
    for (int i = 1; i < 13; i++) send_byte(f[103-8*i -: 8]);
    chk("post_hold_valid", u_if.CmdOutValid, 1);
    chk("post_hold_cmd", u_if.CmdOut, 104'hAA_11111111_22222222_33333333);
    @(negedge clk);

    // Partial frame followed by a long idle gap
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    pulses = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (u_if.FrameDrop) pulses++;
    end
`ifdef TRAFFIC_CMD_TIMEOUT_EN
    chk("timeout_pulses", pulses, 1);
    send_frame(104'h07_0000ABCD_12345678_9ABCDEF0);
    chk("timeout_next_valid", u_if.CmdOutValid, 1);
    chk("timeout_next_cmd", u_if.CmdOut, 104'h07_0000ABCD_12345678_9ABCDEF0);
`else
    chk("no_timeout_pulses", pulses, 0);
    f = 104'h66_778899AA_BBCCDD00_00000000;
    for (int i = 0; i < 7; i++) send_byte(f[103-8*i -: 8]);
    chk("retained_not_done_at_7", u_if.CmdOutValid, 0);
    send_byte(8'hDD);
    chk("retained_valid_at_8", u_if.CmdOutValid, 1);
    chk("retained_cmd", u_if.CmdOut, 104'h11_22334455_66778899_AABBCCDD);
`endif
    @(negedge clk);

    // Reset in the middle of an RX frame and a TX response
    u_if.RespIn = 32'hCAFEF00D;
    u_if.RespInValid = 1'b1;
    @(negedge clk);
    u_if.RespInValid = 1'b0;
    u_if.UARTOutReady = 1'b1;
    repeat (2) @(negedge clk);
    u_if.UARTOutReady = 1'b0;
    f = vec[3].frame;
    for (int i = 0; i < 7; i++) send_byte(f[103-8*i -: 8]);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {u_if.UARTInReady, u_if.CmdOutValid, u_if.RespInReady, u_if.UARTOutValid,
         u_if.FrameDrop, u_if.UARTOut}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    chk("midreset_cmdout", u_if.CmdOut, 0);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.UARTOutReady = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (u_if.UARTOutValid) flag = 1'b1;
    end
    u_if.UARTOutReady = 1'b0;
    chk("no_residual_tx", flag, 0);
    send_frame(vec[0].frame);
    chk("post_reset_valid", u_if.CmdOutValid, 1);
    chk("post_reset_cmd", u_if.CmdOut, 104'h03_00000001_00000064_00000000);
    @(negedge clk);

    // RX frame and TX response together
    fork
      begin
        t0 = cyc;
        send_frame(104'h5C_DEADBEEF_00C0FFEE_01020304);
        rx_cyc   = cyc - t0;
        rx_valid = u_if.CmdOutValid;
        rx_cmd   = u_if.CmdOut;
      end
      begin
        run_tx(32'h12345678, 1'b0, got, rdy_ok, stab_ok, txc);
      end
    join
    chk("conc_rx_cycles", rx_cyc, 13);
    chk("conc_rx_valid", rx_valid, 1);
    chk("conc_rx_cmd", rx_cmd, 104'h5C_DEADBEEF_00C0FFEE_01020304);
    chk("conc_tx_bytes", got, 32'h12345678);
    chk("conc_tx_cycles", txc, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
